// File: rtl/dllp_rx_assembler.sv
// Receive-side DLLP assembler: collects 6-byte DLLPs from the deframer byte stream
// and hands the 32-bit content word downstream. Optional CRC check: DLLP_CRC_CHECK_EN.
module dllp_rx_assembler #(
  parameter int DROP_CNT_W = 8,
  parameter bit BYTE0_LSB  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic [7:0]            in_data,
  output logic [31:0]           packet_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  framing_err,
  output logic                  crc_err,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]  state;
  logic [2:0]  idx;
  logic        stray_seen;
  logic [31:0] sr_p0;
  logic [31:0] cmp_word_p1;
  logic        cmp_vld_p1;

  logic        acc_sop, acc_dat;
  logic        stray, abort, last, hs;
  logic        crc_bad, good, load, ovf;
  logic [2:0]  drop_inc;

  function automatic logic [31:0] shift_in(input logic [31:0] sr, input logic [7:0] b);
    if (BYTE0_LSB) return {b, sr[31:8]};
    else           return {sr[23:0], b};
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] c,
                                                    input logic [2:0] inc);
    logic [DROP_CNT_W:0] s;
    s = {1'b0, c} + (DROP_CNT_W+1)'(inc);
    return s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
  endfunction

`ifdef DLLP_CRC_CHECK_EN
  logic [15:0] crc_p0;
  logic [7:0]  crc_lo_p0;
  logic        cmp_ok_p1;
  logic        crc_err_r;

  // LSB-first serial CRC-16, poly 0x100B
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h100B;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction
`endif

  always_comb begin
    acc_sop = in_valid && in_sop;
    acc_dat = in_valid && !in_sop;
    stray   = (state == IDLE) && acc_dat;
    abort   = (state == COLLECT) && acc_sop;
    last    = (state == COLLECT) && acc_dat && (idx == 3'd5);
    hs      = out_valid && out_ready;
`ifdef DLLP_CRC_CHECK_EN
    crc_bad = cmp_vld_p1 && !cmp_ok_p1;
`else
    crc_bad = 1'b0;
`endif
    good     = cmp_vld_p1 && !crc_bad;
    load     = good && (!out_valid || hs);
    ovf      = good && out_valid && !hs;
    drop_inc = {2'b00, stray && !stray_seen} + {2'b00, abort} + {2'b00, ovf} + {2'b00, crc_bad};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      stray_seen  <= 1'b0;
      cmp_vld_p1  <= 1'b0;
      packet_data <= 32'h0;
      out_valid   <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      framing_err <= stray || abort;
      overflow    <= ovf;
      drop_cnt    <= sat_add(drop_cnt, drop_inc);
      cmp_vld_p1  <= last;
      if (load) begin
        packet_data <= cmp_word_p1;
        out_valid   <= 1'b1;
      end else if (hs) begin
        out_valid   <= 1'b0;
      end
      // A stray run is counted once; any SOP re-arms the stray counter
      if (acc_sop) begin
        state      <= COLLECT;
        idx        <= 3'd1;
        stray_seen <= 1'b0;
      end else if (acc_dat) begin
        if (state == IDLE) begin
          stray_seen <= 1'b1;
        end else if (idx == 3'd5) begin
          state <= IDLE;
          idx   <= 3'd0;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

  // p0: content shift register; p1: completed word awaiting the output slot
  always_ff @(posedge clk) begin
    if (acc_sop)
      sr_p0 <= shift_in(32'h0, in_data);
    else if ((state == COLLECT) && acc_dat && (idx <= 3'd3))
      sr_p0 <= shift_in(sr_p0, in_data);
    if (last)
      cmp_word_p1 <= sr_p0;
  end

`ifdef DLLP_CRC_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_p0    <= 16'h0;
      crc_err_r <= 1'b0;
    end else begin
      crc_err_r <= crc_bad;
      if (acc_sop)
        crc_p0 <= crc_byte(16'hFFFF, in_data);
      else if ((state == COLLECT) && acc_dat && (idx <= 3'd3))
        crc_p0 <= crc_byte(crc_p0, in_data);
    end
  end

  // CRC bytes arrive bit-reversed relative to the complemented LFSR
  always_ff @(posedge clk) begin
    if ((state == COLLECT) && acc_dat && (idx == 3'd4))
      crc_lo_p0 <= in_data;
    if (last)
      cmp_ok_p1 <= (~crc_p0 == {rev8(in_data), rev8(crc_lo_p0)});
  end

  assign crc_err = crc_err_r;
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_dllp_rx_assembler.sv
// Randomized and directed bench for dllp_rx_assembler against a byte-queue reference model.
module tb_dllp_rx_assembler;
  localparam int DROP_CNT_W = 8;
  localparam bit BYTE0_LSB  = 1'b1;
  localparam int CNT_MAX    = (1 << DROP_CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_sop = 1'b0;
  logic [7:0]            in_data = 8'h00;
  logic [31:0]           packet_data;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic                  framing_err;
  logic                  crc_err;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;

  dllp_rx_assembler #(.DROP_CNT_W(DROP_CNT_W), .BYTE0_LSB(BYTE0_LSB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
    .packet_data(packet_data), .out_valid(out_valid), .out_ready(out_ready),
    .framing_err(framing_err), .crc_err(crc_err), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: current DLLP is a queue of bytes, empty means idle
  logic [7:0]  q_cur[$];
  logic [47:0] m_pend_b;
  bit          m_pend, m_has, m_stray, m_fe, m_ov, m_ce;
  logic [31:0] m_word;
  int          m_cnt;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Returns the two CRC bytes {byte5, byte4} a transmitter would send
  function automatic logic [15:0] ref_tail(input logic [31:0] msg);
    logic [15:0] r;
    logic [15:0] e;
    r = 16'hFFFF;
    for (int i = 0; i < 32; i++) r = {r[14:0], 1'b0} ^ ((r[15] ^ msg[i]) ? 16'h100B : 16'h0000);
    e = ~r;
    return {rev8(e[15:8]), rev8(e[7:0])};
  endfunction

  task automatic model_reset();
    q_cur.delete();
    m_pend = 0; m_has = 0; m_stray = 0; m_fe = 0; m_ov = 0; m_ce = 0;
    m_word = 32'h0; m_cnt = 0; m_pend_b = 48'h0;
  endtask

  task automatic step(input bit v, input bit s, input logic [7:0] d, input bit rdy);
    bit hs, next_has, ok;
    int inc;
    logic [31:0] w;
    hs = m_has && rdy;
    next_has = m_has && !hs;
    inc = 0; m_fe = 0; m_ov = 0; m_ce = 0;
    if (m_pend) begin
      w = BYTE0_LSB ? m_pend_b[31:0]
                    : {m_pend_b[7:0], m_pend_b[15:8], m_pend_b[23:16], m_pend_b[31:24]};
      ok = 1;
`ifdef DLLP_CRC_CHECK_EN
      ok = (m_pend_b[47:32] == ref_tail(m_pend_b[31:0]));
`endif
      if (!ok) begin m_ce = 1; inc++; end
      else if (m_has && !hs) begin m_ov = 1; inc++; end
      else begin next_has = 1; m_word = w; end
    end
    m_pend = 0;
    if (v) begin
      if (s) begin
        if (q_cur.size() != 0) begin m_fe = 1; inc++; end
        q_cur.delete();
        q_cur.push_back(d);
        m_stray = 0;
      end else if (q_cur.size() == 0) begin
        m_fe = 1;
        if (!m_stray) inc++;
        m_stray = 1;
      end else begin
        q_cur.push_back(d);
        if (q_cur.size() == 6) begin
          for (int i = 0; i < 6; i++) m_pend_b[8*i +: 8] = q_cur[i];
          m_pend = 1;
          q_cur.delete();
        end
      end
    end
    m_has = next_has;
    m_cnt = (m_cnt + inc > CNT_MAX) ? CNT_MAX : m_cnt + inc;
  endtask

  task automatic check_all();
    check("out_valid",   {31'h0, out_valid},   {31'h0, m_has});
    check("packet_data", packet_data,          m_word);
    check("framing_err", {31'h0, framing_err}, {31'h0, m_fe});
    check("overflow",    {31'h0, overflow},    {31'h0, m_ov});
    check("crc_err",     {31'h0, crc_err},     {31'h0, m_ce});
    check("drop_cnt",    32'(drop_cnt),        32'(m_cnt));
  endtask

  task automatic cyc(input bit v, input bit s, input logic [7:0] d, input bit rdy);
    @(negedge clk);
    in_valid = v; in_sop = s; in_data = d; out_ready = rdy;
    step(v, s, d, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic bit rd(input int m);
    if (m == 2) return ($urandom_range(0, 3) != 0);
    return (m == 1);
  endfunction

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), rd(rmode));
  endtask

  // c holds byte0 in [7:0]; the tail is replaced by a correct CRC when fix_crc is set
  task automatic send_pkt(input logic [31:0] c, input logic [15:0] tail, input bit fix_crc,
                          input int gap_at, input int gap_len, input int rmode);
    logic [47:0] b;
    b = {fix_crc ? ref_tail(c) : tail, c};
    for (int i = 0; i < 6; i++) begin
      if (i == gap_at) idle(gap_len, rmode);
      cyc(1'b1, i == 0, b[8*i +: 8], rd(rmode));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Zero content, tail AA BB
    send_pkt(32'h0000_0000, 16'hBBAA, 1'b1, 6, 0, 1);
    check("t1_not_yet", {31'h0, out_valid}, 32'h0);
    idle(1, 1);
    check("t1_valid", {31'h0, out_valid}, 32'h1);
    check("t1_data", packet_data, 32'h0000_0000);
    check("t1_drop", 32'(drop_cnt), 32'h0);
    idle(2, 1);

    // Gap of three idle cycles before byte 3
    send_pkt(32'h0000_0020, 16'h0000, 1'b1, 3, 3, 1);
    idle(1, 1);
    check("t2_data", packet_data, 32'h0000_0020);
    idle(1, 1);
    check("t2_one_pulse", {31'h0, out_valid}, 32'h0);

    // Back-to-back with output stalled
    do_reset();
    send_pkt(32'h4433_2211, 16'h0000, 1'b1, 6, 0, 0);
    send_pkt(32'h8877_6655, 16'h0000, 1'b1, 6, 0, 0);
    idle(1, 0);
    check("t3_ovf", {31'h0, overflow}, 32'h1);
    check("t3_held", packet_data, 32'h4433_2211);
    check("t3_drop", 32'(drop_cnt), 32'h1);
    idle(1, 1);
    check("t3_hs", {31'h0, out_valid}, 32'h0);
    check("t3_ovf_once", {31'h0, overflow}, 32'h0);

    // SOP again at byte index 3
    do_reset();
    cyc(1'b1, 1'b1, 8'hA0, 1'b1);
    cyc(1'b1, 1'b0, 8'hA1, 1'b1);
    cyc(1'b1, 1'b0, 8'hA2, 1'b1);
    send_pkt(32'hD4C3_B2A1, 16'h0000, 1'b1, 6, 0, 1);
    check("t4_fe_seen", 32'(drop_cnt), 32'h1);
    idle(1, 1);
    check("t4_restart", packet_data, 32'hD4C3_B2A1);

    // Corrupted content with original tail
    do_reset();
    send_pkt(32'h1234_5678, 16'h0000, 1'b1, 6, 0, 1);
    idle(2, 1);
    send_pkt(32'h1235_5678, ref_tail(32'h1234_5678), 1'b0, 6, 0, 1);
    idle(1, 1);
`ifdef DLLP_CRC_CHECK_EN
    check("t5_crc_err", {31'h0, crc_err}, 32'h1);
    check("t5_no_load", {31'h0, out_valid}, 32'h0);
    check("t5_drop", 32'(drop_cnt), 32'h1);
`else
    check("t5_loaded", packet_data, 32'h1235_5678);
`endif

    // Reset mid-DLLP while the output is occupied
    do_reset();
    send_pkt(32'hCAFE_F00D, 16'h0000, 1'b1, 6, 0, 0);
    idle(1, 0);
    cyc(1'b1, 1'b1, 8'h01, 1'b0);
    cyc(1'b1, 1'b0, 8'h02, 1'b0);
    cyc(1'b1, 1'b0, 8'h03, 1'b0);
    check("t6_pre", {31'h0, out_valid}, 32'h1);
    do_reset();
    check("t6_rst_data", packet_data, 32'h0);
    send_pkt(32'h0403_0201, 16'h0000, 1'b1, 6, 0, 1);
    idle(1, 1);
    check("t6_after", packet_data, 32'h0403_0201);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) cyc(1'b1, 1'b0, 8'($urandom), rd(2));
      end else if (kind == 1) begin
        cyc(1'b1, 1'b1, 8'($urandom), rd(2));
        for (int k = 0; k < $urandom_range(0, 4); k++) cyc(1'b1, 1'b0, 8'($urandom), rd(2));
      end else begin
        send_pkt($urandom, 16'($urandom), $urandom_range(0, 7) != 0,
                 $urandom_range(1, 6), $urandom_range(0, 2), 2);
      end
      idle($urandom_range(0, 2), 2);
    end

    // Saturation of the drop counter through repeated aborts
    do_reset();
    for (int k = 0; k < 300; k++) cyc(1'b1, 1'b1, 8'($urandom), 1'b1);
    check("sat_cnt", 32'(drop_cnt), CNT_MAX);
    idle(2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dllp_rx_assembler.md
Name: dllp_rx_assembler

Overview:
Receive-side DLLP assembler in the PCIe data link layer. It consumes the byte stream from the physical-layer deframer and collects each 6-byte DLLP (4 content bytes plus a 2-byte CRC). It then presents the 32-bit content word, with a valid/ready handshake, to the downstream per-type DLLP decoders (NOP2, ACK/NAK, FC). It also flags framing and overflow errors.

Parameters:
DROP_CNT_W, 8, width of the saturating dropped-DLLP counter.
BYTE0_LSB, 1, 1: byte 0 maps to packet_data[7:0] and byte 3 to [31:24]; 0: byte 0 maps to [31:24].

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data/in_sop qualified this cycle.
in_sop  input  1  first byte of a DLLP (byte 0); meaningful only with in_valid.
in_data  input  8  received byte.
packet_data  output  32  assembled DLLP content bytes 0..3.
out_valid  output  1  packet_data holds an unconsumed DLLP.
out_ready  input  1  downstream accepts packet_data when out_valid && out_ready.
framing_err  output  1  one-cycle pulse: DLLP truncated or byte without SOP.
crc_err  output  1  one-cycle pulse: CRC mismatch (with DLLP_CRC_CHECK_EN only).
overflow  output  1  one-cycle pulse: completed DLLP dropped because output was occupied.
drop_cnt  output  DROP_CNT_W  saturating count of DLLPs dropped for any reason.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; packet_data=0, out_valid=0, framing_err=0, crc_err=0, overflow=0, drop_cnt=0; byte index and CRC LFSR cleared.
- Byte acceptance: no input backpressure; a byte is accepted on every cycle with in_valid=1. Gaps (in_valid=0) are allowed anywhere and hold all state.
- FSM states: IDLE and COLLECT; the byte index runs 0..5.
  - IDLE, in_valid && in_sop: store byte 0, index=1, go to COLLECT.
  - IDLE, in_valid && !in_sop: discard the byte, pulse framing_err, increment drop_cnt. The counter counts each stray run of bytes once: only the first stray byte after IDLE entry counts.
  - COLLECT, in_valid && !in_sop: store the byte at the current index (bytes 1..3 go to the content shift register, bytes 4..5 are CRC), then index++.
  - COLLECT, in_valid && in_sop: abort the current DLLP; pulse framing_err; drop_cnt++; the new byte becomes byte 0 (index=1, stay in COLLECT).
  - COLLECT, 6th byte accepted: return to IDLE and run the completion logic.
- Completion, evaluated in the cycle after byte 5 is accepted:
  - If out_valid=1 and no handshake occurs that cycle: discard the new DLLP, pulse overflow, drop_cnt++. Held packet_data is unchanged.
  - If out_valid=0, or a handshake occurs in the same cycle: packet_data is loaded and out_valid=1. A simultaneous accept and load counts as a load, not an overflow.
- Latency: out_valid rises on the clock edge after the edge that accepts byte 5.
- Output holding: packet_data and out_valid are stable while out_valid && !out_ready. out_valid clears on handshake unless a load coincides.
- drop_cnt saturates at all-ones and never wraps.
- The error pulses are registered, one cycle wide, and may coincide with each other.

Optional Feature:
Macro DLLP_CRC_CHECK_EN.
- Defined:
  - CRC-16 uses polynomial 0x100B, seed 0xFFFF.
  - Bytes 0..3 are processed LSB first.
  - The expected value is the bitwise complement of the LFSR.
  - The expected value is compared against {byte5, byte4}, with each byte bit-reversed.
  - On mismatch: no load, pulse crc_err, drop_cnt++.
- Undefined: bytes 4..5 are ignored, every complete DLLP loads, and crc_err is tied to 0.

Test Plan:
- Macro off. Reset, then stream SOP 00,00,00,00,AA,BB with out_ready=1 -> out_valid high one cycle after the last byte, packet_data=32'h00000000, drop_cnt=0.
- Macro off. Stream SOP 20,00,00,00,xx,xx with an in_valid gap of 3 cycles between bytes 2 and 3 -> packet_data=32'h00000020, single out_valid pulse.
- Macro off. Two back-to-back DLLPs 11,22,33,44 and 55,66,77,88 with out_ready=0 -> first word 32'h44332211 is held; overflow pulses once; drop_cnt=1. Then out_ready=1 -> one handshake.
- SOP asserted again at byte index 3 -> framing_err pulse, drop_cnt=1, and the restarted DLLP completes normally.
- Macro on. A DLLP with model-computed CRC loads with crc_err=0. The same DLLP with bit 0 of byte 2 flipped -> no out_valid, crc_err pulse, drop_cnt=1.
- Assert rst mid-DLLP (index 3) with out_valid=1 -> all outputs 0 immediately. A following full DLLP assembles correctly.
